apu_dmc_dma_ctrl: RTL and testbench

// - Services the DMC sample-fetch DMA request from apu_gen2.
// - Halts the 6502 core through cpu_rdy and takes the CPU bus.
// - Reads one byte from $8000-$FFFF and returns it with a one-clock dma_ack.
// - Sits between apu_gen2 (dma_req/dma_address/dma_ack/from_mem) and the CPU bus mux.

---
 rtl/apu_dmc_dma_if.sv | 38 +++
 rtl/apu_dmc_dma_ctrl.sv | 156 +++++++++++++++
 tb/tb_apu_dmc_dma_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/apu_dmc_dma_if.sv
// apu_dmc_dma_if
// Groups the DMC request/acknowledge handshake and the CPU bus signals that
// the DMC sample-fetch DMA controller observes or drives.
//   slave  modport : the DMA controller (apu_dmc_dma_ctrl)
//   master modport : the surroundings (DMC channel, CPU core, bus mux)
// Signals:
//   dma_req      level request from the DMC, held until dma_ack
//   dma_address  sample address from the DMC (ADDR_W bits)
//   dma_ack      one-clk pulse, fetched byte valid
//   from_mem     fetched byte, held until the next fetch
//   cpu_r_nw     CPU cycle type of the current cycle (1 = read)
//   mem_data     bus read data
//   cpu_rdy      0 = CPU halted
//   bus_own      1 = DMA drives bus_addr, CPU address masked
//   bus_addr     DMA bus address
interface apu_dmc_dma_if #(
  parameter int ADDR_W = 15
);
  logic              dma_req;
  logic [ADDR_W-1:0] dma_address;
  logic              dma_ack;
  logic [7:0]        from_mem;
  logic              cpu_r_nw;
  logic [7:0]        mem_data;
  logic              cpu_rdy;
  logic              bus_own;
  logic [15:0]       bus_addr;

  modport slave (
    input  dma_req, dma_address, cpu_r_nw, mem_data,
    output dma_ack, from_mem, cpu_rdy, bus_own, bus_addr
  );

  modport master (
    output dma_req, dma_address, cpu_r_nw, mem_data,
    input  dma_ack, from_mem, cpu_rdy, bus_own, bus_addr
  );
endinterface

// File: rtl/apu_dmc_dma_ctrl.sv
// apu_dmc_dma_ctrl
// Services the DMC sample-fetch DMA request: halts the 6502 through cpu_rdy,
// waits for the CPU to stop on a read cycle, burns DUMMY_CYCLES halted
// cycles, then takes the bus for one read of {1'b1, dma_address} and returns
// the byte with a one-clk dma_ack.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   cpu_clk    CPU cycle enable, one clk pulse per CPU cycle
//   apu_phase  APU get/put parity, toggles each CPU cycle
//   bus        apu_dmc_dma_if.slave (request/ack handshake and CPU bus)
// Parameters:
//   DUMMY_CYCLES  halted CPU cycles between halt and read (1..3)
// Build option:
//   APU_DMA_PARITY_ALIGN_EN  when defined, the read is forced onto
//   apu_phase=0 by inserting one ALIGN cycle when needed; when undefined the
//   stall is a fixed DUMMY_CYCLES+2 CPU cycles after the halt.
module apu_dmc_dma_ctrl #(
  parameter int DUMMY_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_clk,
  input  logic         apu_phase,
  apu_dmc_dma_if.slave bus
);

`ifdef APU_DMA_PARITY_ALIGN_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam logic [1:0] CNT_LOAD = 2'(DUMMY_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    DUMMY,
    ALIGN,
    READ
  } state_t;

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic        cool, cool_n;
  logic        rdy_q, rdy_n;
  logic        own_q, own_n;
  logic [15:0] addr_q, addr_n;
  logic        ack_q, ack_n;
  logic [7:0]  data_q, data_n;

  // State and all outputs are registered; everything moves on cpu_clk
  // except dma_ack, which is cleared on the very next clk so it lasts one clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      cool   <= 1'b0;
      rdy_q  <= 1'b1;
      own_q  <= 1'b0;
      addr_q <= 16'h0000;
      ack_q  <= 1'b0;
      data_q <= 8'h00;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      cool   <= cool_n;
      rdy_q  <= rdy_n;
      own_q  <= own_n;
      addr_q <= addr_n;
      ack_q  <= ack_n;
      data_q <= data_n;
    end
  end

  // Next-state and next-output logic. 'cool' blocks a still-high dma_req for
  // the one CPU cycle after an ack so back-to-back fetches never merge.
  // A dropped dma_req before READ aborts and releases the CPU; once in READ
  // the fetch always completes.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cool_n  = cool;
    rdy_n   = rdy_q;
    own_n   = own_q;
    addr_n  = addr_q;
    ack_n   = 1'b0;
    data_n  = data_q;

    if (cpu_clk) begin
      cool_n = 1'b0;
      case (state)
        IDLE: begin
          if (bus.dma_req && !cool) begin
            state_n = HALT;
            rdy_n   = 1'b0;
          end
        end
        HALT: begin
          if (!bus.dma_req) begin
            state_n = IDLE;
            rdy_n   = 1'b1;
          end else if (bus.cpu_r_nw) begin
            state_n = DUMMY;
            cnt_n   = CNT_LOAD;
          end
        end
        DUMMY: begin
          if (!bus.dma_req) begin
            state_n = IDLE;
            rdy_n   = 1'b1;
          end else if (cnt != 2'd0) begin
            cnt_n = cnt - 2'd1;
          end else if (PARITY_EN && !apu_phase) begin
            state_n = ALIGN;
          end else begin
            state_n = READ;
            own_n   = 1'b1;
            addr_n  = {1'b1, bus.dma_address};
          end
        end
        ALIGN: begin
          if (!bus.dma_req) begin
            state_n = IDLE;
            rdy_n   = 1'b1;
          end else begin
            state_n = READ;
            own_n   = 1'b1;
            addr_n  = {1'b1, bus.dma_address};
          end
        end
        READ: begin
          state_n = IDLE;
          data_n  = bus.mem_data;
          ack_n   = 1'b1;
          rdy_n   = 1'b1;
          own_n   = 1'b0;
          cool_n  = 1'b1;
        end
        default: begin
          state_n = IDLE;
          rdy_n   = 1'b1;
          own_n   = 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_rdy  = rdy_q;
  assign bus.bus_own  = own_q;
  assign bus.bus_addr = addr_q;
  assign bus.dma_ack  = ack_q;
  assign bus.from_mem = data_q;

endmodule

// File: tb/tb_apu_dmc_dma_ctrl.sv
// tb_apu_dmc_dma_ctrl
// Directed bench for apu_dmc_dma_ctrl (DUMMY_CYCLES=1). Each table record is
// one CPU cycle: inputs applied before the cpu_clk pulse, outputs compared
// at the following falling clk edge.
module tb_apu_dmc_dma_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_clk = 1'b0;
  logic apu_phase = 1'b0;

  int checks = 0;
  int passes = 0;

  apu_dmc_dma_if #(.ADDR_W(15)) bus ();

  apu_dmc_dma_ctrl #(.DUMMY_CYCLES(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_clk   (cpu_clk),
    .apu_phase (apu_phase),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        r_nw;
    logic        phase;
    logic [14:0] addr;
    logic [7:0]  mem;
    logic        e_rdy;
    logic        e_own;
    logic        e_ack;
    logic [15:0] e_addr;
    logic [7:0]  e_from;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic req, input logic r_nw, input logic phase,
                              input logic [14:0] addr, input logic [7:0] mem,
                              input logic e_rdy, input logic e_own, input logic e_ack,
                              input logic [15:0] e_addr, input logic [7:0] e_from);
    vec_t v;
    v.req = req; v.r_nw = r_nw; v.phase = phase; v.addr = addr; v.mem = mem;
    v.e_rdy = e_rdy; v.e_own = e_own; v.e_ack = e_ack; v.e_addr = e_addr; v.e_from = e_from;
    return v;
  endfunction

  // Three quiet clks, then one clk with cpu_clk high; returns at the falling
  // edge right after the active edge.
  task automatic cpuCycle();
    repeat (3) @(negedge clk);
    cpu_clk = 1'b1;
    @(negedge clk);
    cpu_clk = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    else
      passes++;
  endtask

  task automatic applyStimulus(input logic req, input logic r_nw, input logic phase,
                               input logic [14:0] addr, input logic [7:0] mem);
    bus.dma_req     = req;
    bus.cpu_r_nw    = r_nw;
    apu_phase       = phase;
    bus.dma_address = addr;
    bus.mem_data    = mem;
    cpuCycle();
  endtask

  // Halts the CPU with a fresh request, then counts CPU cycles until cpu_rdy
  // returns; ph_end is the apu_phase seen at the cpu_clk that ends DUMMY.
  task automatic measureStall(input logic ph_end, output int stall);
    stall = 0;
    applyStimulus(1'b1, 1'b1, ~ph_end, 15'h0555, 8'h00);
    if (bus.cpu_rdy === 1'b0) stall = 1;
    for (int i = 1; i <= 12 && bus.cpu_rdy === 1'b0; i++) begin
      applyStimulus(1'b1, 1'b1, (i == 2) ? ph_end : ~ph_end, 15'h0555, 8'h5A);
      if (bus.cpu_rdy === 1'b0) stall++;
    end
    if (bus.cpu_rdy !== 1'b1) begin
      checks++;
      $display("[TB] FAIL stall timeout: cpu_rdy %b still low after 12 cycles", bus.cpu_rdy);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 15'h0555, 8'h00);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stall;
    int exp_stall;

    // Fetch, abort in DUMMY, three CPU writes before the halt lands,
    // back-to-back fetches with the one-cycle ignore and a req drop in READ.
    vecs[0]  = mk(1'b1,1'b1,1'b0,15'h4123,8'h00, 1'b0,1'b0,1'b0,16'h0000,8'h00);
    vecs[1]  = mk(1'b1,1'b1,1'b0,15'h4123,8'h00, 1'b0,1'b0,1'b0,16'h0000,8'h00);
    vecs[2]  = mk(1'b1,1'b1,1'b1,15'h4123,8'h00, 1'b0,1'b1,1'b0,16'hC123,8'h00);
    vecs[3]  = mk(1'b1,1'b1,1'b0,15'h0001,8'hA5, 1'b1,1'b0,1'b1,16'hC123,8'hA5);
    vecs[4]  = mk(1'b0,1'b1,1'b1,15'h0001,8'h00, 1'b1,1'b0,1'b0,16'hC123,8'hA5);
    vecs[5]  = mk(1'b1,1'b1,1'b0,15'h1111,8'h00, 1'b0,1'b0,1'b0,16'hC123,8'hA5);
    vecs[6]  = mk(1'b1,1'b1,1'b1,15'h1111,8'h00, 1'b0,1'b0,1'b0,16'hC123,8'hA5);
    vecs[7]  = mk(1'b0,1'b1,1'b1,15'h1111,8'h77, 1'b1,1'b0,1'b0,16'hC123,8'hA5);
    vecs[8]  = mk(1'b0,1'b1,1'b0,15'h1111,8'h77, 1'b1,1'b0,1'b0,16'hC123,8'hA5);
    vecs[9]  = mk(1'b1,1'b0,1'b0,15'h2000,8'h00, 1'b0,1'b0,1'b0,16'hC123,8'hA5);
    vecs[10] = mk(1'b1,1'b0,1'b1,15'h2000,8'h00, 1'b0,1'b0,1'b0,16'hC123,8'hA5);
    vecs[11] = mk(1'b1,1'b0,1'b0,15'h2000,8'h00, 1'b0,1'b0,1'b0,16'hC123,8'hA5);
    vecs[12] = mk(1'b1,1'b0,1'b1,15'h2000,8'h00, 1'b0,1'b0,1'b0,16'hC123,8'hA5);
    vecs[13] = mk(1'b1,1'b1,1'b0,15'h2000,8'h00, 1'b0,1'b0,1'b0,16'hC123,8'hA5);
    vecs[14] = mk(1'b1,1'b1,1'b1,15'h2000,8'h00, 1'b0,1'b1,1'b0,16'hA000,8'hA5);
    vecs[15] = mk(1'b1,1'b1,1'b0,15'h2000,8'h3C, 1'b1,1'b0,1'b1,16'hA000,8'h3C);
    vecs[16] = mk(1'b0,1'b1,1'b1,15'h2000,8'h00, 1'b1,1'b0,1'b0,16'hA000,8'h3C);
    vecs[17] = mk(1'b1,1'b1,1'b0,15'h7FFF,8'h00, 1'b0,1'b0,1'b0,16'hA000,8'h3C);
    vecs[18] = mk(1'b1,1'b1,1'b0,15'h7FFF,8'h00, 1'b0,1'b0,1'b0,16'hA000,8'h3C);
    vecs[19] = mk(1'b1,1'b1,1'b1,15'h7FFF,8'h00, 1'b0,1'b1,1'b0,16'hFFFF,8'h3C);
    vecs[20] = mk(1'b1,1'b1,1'b0,15'h7FFF,8'h11, 1'b1,1'b0,1'b1,16'hFFFF,8'h11);
    vecs[21] = mk(1'b1,1'b1,1'b1,15'h0000,8'h00, 1'b1,1'b0,1'b0,16'hFFFF,8'h11);
    vecs[22] = mk(1'b1,1'b1,1'b0,15'h0000,8'h00, 1'b0,1'b0,1'b0,16'hFFFF,8'h11);
    vecs[23] = mk(1'b1,1'b1,1'b0,15'h0000,8'h00, 1'b0,1'b0,1'b0,16'hFFFF,8'h11);
    vecs[24] = mk(1'b1,1'b1,1'b1,15'h0000,8'h00, 1'b0,1'b1,1'b0,16'h8000,8'h11);
    vecs[25] = mk(1'b0,1'b1,1'b0,15'h3333,8'h22, 1'b1,1'b0,1'b1,16'h8000,8'h22);
    vecs[26] = mk(1'b0,1'b1,1'b1,15'h3333,8'h00, 1'b1,1'b0,1'b0,16'h8000,8'h22);

    bus.dma_req     = 1'b0;
    bus.cpu_r_nw    = 1'b1;
    bus.dma_address = 15'h0000;
    bus.mem_data    = 8'h00;

    repeat (2) @(negedge clk);
    checkOutput("reset rdy",  16'(bus.cpu_rdy),  16'h0001);
    checkOutput("reset own",  16'(bus.bus_own),  16'h0000);
    checkOutput("reset ack",  16'(bus.dma_ack),  16'h0000);
    checkOutput("reset addr", bus.bus_addr,      16'h0000);
    checkOutput("reset from", 16'(bus.from_mem), 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].req, vecs[i].r_nw, vecs[i].phase, vecs[i].addr, vecs[i].mem);
      checkOutput($sformatf("v%0d rdy", i),  16'(bus.cpu_rdy),  16'(vecs[i].e_rdy));
      checkOutput($sformatf("v%0d own", i),  16'(bus.bus_own),  16'(vecs[i].e_own));
      checkOutput($sformatf("v%0d ack", i),  16'(bus.dma_ack),  16'(vecs[i].e_ack));
      checkOutput($sformatf("v%0d addr", i), bus.bus_addr,      vecs[i].e_addr);
      checkOutput($sformatf("v%0d from", i), 16'(bus.from_mem), 16'(vecs[i].e_from));
      if (vecs[i].e_ack) begin
        @(negedge clk);
        checkOutput($sformatf("v%0d ack width", i), 16'(bus.dma_ack), 16'h0000);
      end
    end

    // Parity alignment: READ must land on apu_phase=0 only when enabled.
`ifdef APU_DMA_PARITY_ALIGN_EN
    exp_stall = 4;
`else
    exp_stall = 3;
`endif
    measureStall(1'b0, stall);
    checkOutput("stall phase0", 16'(stall), 16'(exp_stall));
    measureStall(1'b1, stall);
    checkOutput("stall phase1", 16'(stall), 16'h0003);
    checkOutput("stall from", 16'(bus.from_mem), 16'h005A);

    // Async reset in the middle of READ, between cpu_clk pulses.
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h1234, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h1234, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 15'h1234, 8'h00);
    checkOutput("pre-rst own",  16'(bus.bus_own), 16'h0001);
    checkOutput("pre-rst addr", bus.bus_addr,     16'h9234);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst rdy",  16'(bus.cpu_rdy),  16'h0001);
    checkOutput("rst own",  16'(bus.bus_own),  16'h0000);
    checkOutput("rst ack",  16'(bus.dma_ack),  16'h0000);
    checkOutput("rst addr", bus.bus_addr,      16'h0000);
    checkOutput("rst from", 16'(bus.from_mem), 16'h0000);
    bus.dma_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 15'h1234, 8'hEE);
    checkOutput("post-rst rdy",  16'(bus.cpu_rdy),  16'h0001);
    checkOutput("post-rst from", 16'(bus.from_mem), 16'h0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
